shift_register_scroller: RTL and testbench
==========================================

// Module: shift_register_scroller
// PURPOSE
//   Parametrised universal shift register for the display scroll path. Holds, shifts
//   (serial-in), rotates or parallel-loads a WIDTH-bit column pattern, in either direction.
//   An internal prescaler paces the shifts. A step counter flags each full pattern pass.
//   The serial output chains registers so that a letter can scroll across cascaded stages.
// PARAMETERS
//   WIDTH   7   register length in bits (>=2)
//   DIV_W   8   prescaler width; shift period = tick_div+1 clocks
// PORTS
//   clk         in   1        single clock, all state on rising edge
//   rst_n       in   1        synchronous, active-low reset
//   mode        in   2        00 hold, 01 shift (serial_in), 10 rotate, 11 parallel load
//   dir         in   1        0: q[i]<=q[i-1] (toward MSB); 1: q[i]<=q[i+1] (toward LSB)
//   serial_in   in   1        bit entering the register in shift mode
//   par_in      in   WIDTH    parallel load value
//   tick_div    in   DIV_W    prescaler terminal count
//   q           out  WIDTH    register contents
//   serial_out  out  1        chain output (combinational from q and mode)
//   step_tick   out  1        1-cycle pulse on every clock in which a shift/rotate happens
//   pass_done   out  1        1-cycle pulse when step_cnt wraps WIDTH-1 -> 0
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge): q=0, prescaler=0, step_cnt=0, step_tick=0, pass_done=0.
//     Reset has priority over every mode, including a load. Reset mid-scroll discards state.
//   - Prescaler runs only in modes 01/10: when cnt==tick_div, set step_tick=1 (registered,
//     same edge as the shift) and set cnt=0. Otherwise cnt++. tick_div=0 shifts every clock.
//     If tick_div is lowered below the current cnt, cnt wraps naturally through 2^DIV_W
//     (no early tick).
//   - mode 00: q, prescaler and step_cnt are frozen. Outputs step_tick and pass_done are 0.
//   - mode 01, on tick: dir=0 -> q<={q[WIDTH-2:0],serial_in}; dir=1 -> q<={serial_in,q[WIDTH-1:1]}.
//   - mode 10, on tick: dir=0 -> q<={q[WIDTH-2:0],q[WIDTH-1]}; dir=1 -> q<={q[0],q[WIDTH-1:1]}.
//   - mode 11: q<=par_in on every clock (not tick-gated). Prescaler, step_cnt=0. No pulses.
//   - step_cnt ($clog2(WIDTH) bits) increments on each tick. At WIDTH-1 it wraps to 0 and
//     pass_done pulses on that same edge.
//   - Switching between 01 and 10 (or toggling dir) keeps prescaler and step_cnt. The new
//     mode applies at the next tick.
//   - serial_out = (mode==01) ? q[0] : mode[1] ? q[WIDTH-1] : 0. In mode 1x this output
//     keeps presenting the end bit, so a downstream stage stays stable while this one holds
//     a letter.
//   - Latency: a shift is visible on q one clock after the tick-qualifying edge. A load is
//     visible the clock after mode=11 is sampled.
// STRUCTURE
//   - Shared package scroll_pkg: mode encodings MODE_HOLD/SHIFT/ROTATE/LOAD (2-bit) and
//     DIR_UP/DIR_DOWN constants.
//   - One sub-module: scroll_prescaler (DIV_W counter, enable, clear, tick_div -> tick).
//     The shift datapath and step counter stay inline.
// TESTING
//   1. Reset, then mode=11 with par_in=7'b1010011 -> q=1010011 after 1 clk. step_tick and
//      pass_done stay 0.
//   2. Load 7'b0000001, mode=10, dir=0, tick_div=0 -> q=0000010,0000100,... After 7 clocks
//      q=0000001 again and pass_done pulses exactly on the 7th shift.
//   3. mode=01, dir=1, serial_in=1, tick_div=3, q=0 -> step_tick every 4th clk. q goes
//      1000000, 1100000, ... serial_out tracks q[0].
//   4. Mid-rotate, drive rst_n=0 together with mode=11 -> q=0 and counters=0. Load ignored.
//   5. Rotate 3 steps, switch to mode 00 for 10 clks, then back to 10 -> q frozen,
//      step_cnt resumes at 3. pass_done arrives after 4 more ticks.
//   6. mode=10 with q[6]=1 -> serial_out=1. mode=00 -> serial_out=0. mode=01 with
//      q[0]=0 -> serial_out=0.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared encodings for the display scroll path.
package scroll_pkg;
    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;
    localparam logic       DIR_UP      = 1'b0;
    localparam logic       DIR_DOWN    = 1'b1;
endpackage

// File: rtl/scroll_prescaler.sv
// Free-running divider that paces scroll steps.
module scroll_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] tick_div_i,
    output logic             tick_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Exact match only: lowering tick_div below cnt wraps through 2^DIV_W
    assign tick_o = en_i && (cnt_q == tick_div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/shift_register_scroller.sv
// Universal shift/rotate/load register with paced steps and pass flag.
module shift_register_scroller
    import scroll_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] par_in,
    input  logic [DIV_W-1:0] tick_div,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             step_tick,
    output logic             pass_done
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    step_q, step_d;
    logic             tick_q, tick_d;
    logic             pass_q, pass_d;
    logic             tick, run, load, last, in_bit;

    assign run  = (mode == MODE_SHIFT) || (mode == MODE_ROTATE);
    assign load = (mode == MODE_LOAD);
    assign last = (step_q == CW'(WIDTH - 1));

    scroll_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (run),
        .clr_i      (load),
        .tick_div_i (tick_div),
        .tick_o     (tick)
    );

    assign in_bit = (mode == MODE_SHIFT) ? serial_in
                  : (dir == DIR_DOWN) ? q_q[0] : q_q[WIDTH-1];

    always_comb begin
        q_d    = q_q;
        step_d = step_q;
        tick_d = 1'b0;
        pass_d = 1'b0;
        if (load) begin
            q_d    = par_in;
            step_d = '0;
        end else if (tick) begin
            q_d    = (dir == DIR_DOWN) ? {in_bit, q_q[WIDTH-1:1]}
                                       : {q_q[WIDTH-2:0], in_bit};
            step_d = last ? '0 : step_q + 1'b1;
            tick_d = 1'b1;
            pass_d = last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q    <= '0;
            step_q <= '0;
            tick_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            step_q <= step_d;
            tick_q <= tick_d;
            pass_q <= pass_d;
        end
    end

    // Rotate/load keep presenting the MSB so a downstream stage stays stable
    always_comb begin
        serial_out = 1'b0;
        unique case (1'b1)
            (mode == MODE_SHIFT): serial_out = q_q[0];
            mode[1]:              serial_out = q_q[WIDTH-1];
            default:              serial_out = 1'b0;
        endcase
    end

    assign q         = q_q;
    assign step_tick = tick_q;
    assign pass_done = pass_q;
endmodule

// File: tb/tb_shift_register_scroller.sv
// Self-checking bench for shift_register_scroller.
module tb_shift_register_scroller;
    import scroll_pkg::*;

    localparam int W  = 7;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = MODE_HOLD;
    logic          dir = 1'b0;
    logic          sin = 1'b0;
    logic [W-1:0]  par = '0;
    logic [DW-1:0] tdiv = '0;
    logic [W-1:0]  q;
    logic          sout, st, pd;

    shift_register_scroller #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .dir        (dir),
        .serial_in  (sin),
        .par_in     (par),
        .tick_div   (tdiv),
        .q          (q),
        .serial_out (sout),
        .step_tick  (st),
        .pass_done  (pd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic         st;
        logic         pd;
    } exp_t;

    typedef struct {
        logic         rn;
        logic [1:0]   md;
        logic [W-1:0] p;
        logic [W-1:0] eq;
        logic         est;
        logic         epd;
    } vec_t;

    exp_t         sb[$];
    vec_t         tbl[10];
    logic [W-1:0] m_q = '0;
    int           m_cnt = 0;
    int           m_step = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour of one rising edge for the current inputs
    task automatic model_edge();
        exp_t e;
        logic inb;
        e.st = 1'b0;
        e.pd = 1'b0;
        if (!rst_n) begin
            m_q = '0; m_cnt = 0; m_step = 0;
        end else if (mode == MODE_LOAD) begin
            m_q = par; m_cnt = 0; m_step = 0;
        end else if (mode != MODE_HOLD) begin
            if (m_cnt == int'(tdiv)) begin
                m_cnt = 0;
                e.st = 1'b1;
                e.pd = (m_step == W - 1);
                m_step = (m_step == W - 1) ? 0 : m_step + 1;
                if (mode == MODE_SHIFT) inb = sin;
                else inb = dir ? m_q[0] : m_q[W-1];
                if (dir == DIR_UP) m_q = (m_q << 1) | W'(inb);
                else m_q = (m_q >> 1) | (W'(inb) << (W - 1));
            end else begin
                m_cnt = (m_cnt + 1) % (1 << DW);
            end
        end
        e.q = m_q;
        sb.push_back(e);
    endtask

    function automatic logic exp_sout();
        if (mode == MODE_SHIFT) return m_q[0];
        if (mode[1]) return m_q[W-1];
        return 1'b0;
    endfunction

    task automatic cyc();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("sb_q", q, e.q);
            check("sb_tick", st, e.st);
            check("sb_pass", pd, e.pd);
            check("sb_sout", sout, exp_sout());
        end
    endtask

    task automatic drive(input logic rn, input logic [1:0] md,
                         input logic d, input logic s,
                         input logic [W-1:0] p, input logic [DW-1:0] td);
        rst_n = rn; mode = md; dir = d; sin = s; par = p; tdiv = td;
    endtask

    initial begin
        tbl[0] = '{1'b0, MODE_LOAD,   7'h7f,       7'b0000000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, MODE_LOAD,   7'b1010011,  7'b1010011, 1'b0, 1'b0};
        tbl[2] = '{1'b1, MODE_LOAD,   7'b0000001,  7'b0000001, 1'b0, 1'b0};
        tbl[3] = '{1'b1, MODE_ROTATE, 7'h00,       7'b0000010, 1'b1, 1'b0};
        tbl[4] = '{1'b1, MODE_ROTATE, 7'h00,       7'b0000100, 1'b1, 1'b0};
        tbl[5] = '{1'b1, MODE_ROTATE, 7'h00,       7'b0001000, 1'b1, 1'b0};
        tbl[6] = '{1'b1, MODE_ROTATE, 7'h00,       7'b0010000, 1'b1, 1'b0};
        tbl[7] = '{1'b1, MODE_ROTATE, 7'h00,       7'b0100000, 1'b1, 1'b0};
        tbl[8] = '{1'b1, MODE_ROTATE, 7'h00,       7'b1000000, 1'b1, 1'b0};
        tbl[9] = '{1'b1, MODE_ROTATE, 7'h00,       7'b0000001, 1'b1, 1'b1};

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rn, tbl[i].md, DIR_UP, 1'b0, tbl[i].p, '0);
            cyc();
            check($sformatf("tbl%0d_q", i), q, tbl[i].eq);
            check($sformatf("tbl%0d_tick", i), st, tbl[i].est);
            check($sformatf("tbl%0d_pass", i), pd, tbl[i].epd);
        end

        // Serial shift toward LSB, one step every 4 clocks
        drive(1'b1, MODE_LOAD, DIR_UP, 1'b0, '0, 8'd3);
        cyc();
        drive(1'b1, MODE_SHIFT, DIR_DOWN, 1'b1, '0, 8'd3);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("t3_tick", st, (k % 4 == 0));
        end
        check("t3_q", q, 7'b1100000);
        check("t3_sout", sout, 1'b0);

        // Reset wins over a simultaneous load mid-rotate
        drive(1'b1, MODE_LOAD, DIR_UP, 1'b0, 7'b0000001, '0);
        cyc();
        drive(1'b1, MODE_ROTATE, DIR_UP, 1'b0, '0, '0);
        cyc();
        cyc();
        drive(1'b0, MODE_LOAD, DIR_UP, 1'b0, 7'h7f, '0);
        cyc();
        check("t4_q", q, 7'b0000000);
        check("t4_tick", st, 1'b0);

        // Hold freezes step count; pass arrives after 4 more ticks
        drive(1'b1, MODE_LOAD, DIR_UP, 1'b0, 7'b0000001, '0);
        cyc();
        drive(1'b1, MODE_ROTATE, DIR_UP, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) cyc();
        drive(1'b1, MODE_HOLD, DIR_UP, 1'b0, '0, '0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("t5_hold_tick", st, 1'b0);
        end
        check("t5_hold_q", q, 7'b0001000);
        drive(1'b1, MODE_ROTATE, DIR_UP, 1'b0, '0, '0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("t5_pass", pd, (k == 4));
        end
        check("t5_q", q, 7'b0000001);

        // serial_out selection, combinational
        drive(1'b1, MODE_LOAD, DIR_UP, 1'b0, 7'b1000000, 8'd200);
        cyc();
        mode = MODE_ROTATE;
        #1 check("t6_rot", sout, 1'b1);
        mode = MODE_HOLD;
        #1 check("t6_hold", sout, 1'b0);
        mode = MODE_SHIFT;
        #1 check("t6_shift", sout, 1'b0);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            int r;
            logic [1:0] md;
            r = $urandom_range(0, 9);
            md = (r == 0) ? MODE_HOLD : (r == 1) ? MODE_LOAD
               : ($urandom_range(0, 1) != 0) ? MODE_SHIFT : MODE_ROTATE;
            drive(($urandom_range(0, 49) != 0), md,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  W'($urandom), DW'($urandom_range(0, 3)));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
